// File: rtl/shift_pkg.sv
`default_nettype none
// ============================================================================
// Module  : shift_pkg
// Purpose : Definitions shared by the A:B shift-chain transmit and receive
//           sides: receiver state encoding, frame geometry, and bit order.
// Ports   : none (package)
// Rev     : 1.0  initial release
// ============================================================================
package shift_pkg;

  // Width of one half (A or B) of the chain word.
  localparam int PKG_HALF_W = 8;

  // Bits per frame on the serial link.
  localparam int FRAME_BITS = 2 * PKG_HALF_W;

  // The chain is shifted out B[0] first, A[7] last.
  localparam bit LSB_FIRST = 1'b1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RECV = 2'd1,
    HOLD = 2'd2
  } deser_state_t;

endpackage : shift_pkg
`default_nettype wire

// File: rtl/deser_shift_reg.sv
`default_nettype none
// ============================================================================
// Module  : deser_shift_reg
// Purpose : W-bit right-shift register; new serial bits enter at the MSB so
//           that after W LSB-first shifts Q equals the transmitted word.
// Ports   : Clk      - rising-edge clock
//           Reset_n  - asynchronous active-low reset, clears Q
//           Shift_En - shift one bit this cycle
//           Shift_In - serial data bit
//           Q        - register contents
// Rev     : 1.0  initial release
// ============================================================================
module deser_shift_reg
  import shift_pkg::*;
#(
  parameter int W = FRAME_BITS
) (
  input  logic         Clk,
  input  logic         Reset_n,
  input  logic         Shift_En,
  input  logic         Shift_In,
  output logic [W-1:0] Q
);

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      Q <= '0;
    end else if (Shift_En) begin
      Q <= {Shift_In, Q[W-1:1]};
    end
  end

endmodule : deser_shift_reg
`default_nettype wire

// File: rtl/shift_deser_16.sv
`default_nettype none
// ============================================================================
// Module  : shift_deser_16
// Purpose : Serial-to-parallel receiver for the 16-bit A:B shift chain.
//           Collects an LSB-first frame, holds the rebuilt word with a
//           valid/ack handshake and flags bits dropped while holding.
// Ports   : Clk      - rising-edge clock
//           Reset_n  - asynchronous active-low reset
//           Start    - begin a new frame (clears bit count)
//           Shift_En - Shift_In is valid this cycle
//           Shift_In - serial data bit
//           Ack      - consumer has taken the held word
//           Busy     - frame reception in progress
//           Valid    - complete word held
//           Overrun  - sticky: a bit arrived and was dropped while holding
//           Aout     - upper half of the word
//           Bout     - lower half of the word
// Rev     : 1.0  initial release
// ============================================================================
module shift_deser_16
  import shift_pkg::*;
#(
  parameter int HALF_W = 8
) (
  input  logic              Clk,
  input  logic              Reset_n,
  input  logic              Start,
  input  logic              Shift_En,
  input  logic              Shift_In,
  input  logic              Ack,
  output logic              Busy,
  output logic              Valid,
  output logic              Overrun,
  output logic [HALF_W-1:0] Aout,
  output logic [HALF_W-1:0] Bout
);

  localparam int FW = 2 * HALF_W;
  localparam int CW = $clog2(FW);

  deser_state_t  state;
  logic [CW-1:0] cnt;
  logic [FW-1:0] sr;
  logic          shift_ok;

  // A bit is taken only while receiving; a restart cycle discards its bit.
  assign shift_ok = (state == RECV) && !Start && Shift_En;

  deser_shift_reg #(
    .W (FW)
  ) u_sr (
    .Clk      (Clk),
    .Reset_n  (Reset_n),
    .Shift_En (shift_ok),
    .Shift_In (Shift_In),
    .Q        (sr)
  );

  assign Aout = sr[FW-1:HALF_W];
  assign Bout = sr[HALF_W-1:0];

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state   <= IDLE;
      cnt     <= '0;
      Busy    <= 1'b0;
      Valid   <= 1'b0;
      Overrun <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (Start) begin
            state   <= RECV;
            cnt     <= '0;
            Busy    <= 1'b1;
            Overrun <= 1'b0;
          end
        end

        RECV: begin
          if (Start) begin
            cnt     <= '0;
            Overrun <= 1'b0;
          end else if (Shift_En) begin
            if (cnt == CW'(FW - 1)) begin
              state <= HOLD;
              cnt   <= '0;
              Busy  <= 1'b0;
              Valid <= 1'b1;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end

        HOLD: begin
          if (Ack) begin
            Valid <= 1'b0;
            if (Start) begin
              state <= RECV;
              cnt   <= '0;
              Busy  <= 1'b1;
            end else begin
              state <= IDLE;
            end
          end else if (Shift_En) begin
            // Word not yet taken: the bit is lost, remember that it was.
            Overrun <= 1'b1;
          end
        end

        default: begin
          state <= IDLE;
          cnt   <= '0;
          Busy  <= 1'b0;
          Valid <= 1'b0;
        end
      endcase
    end
  end

endmodule : shift_deser_16
`default_nettype wire

// File: tb/tb_shift_deser_16.sv
`default_nettype none
// ============================================================================
// Module  : tb_shift_deser_16
// Purpose : Self-checking bench for shift_deser_16. Expected words are queued
//           when a frame is sent and popped when Valid is observed.
// Rev     : 1.0  initial release
// ============================================================================
module tb_shift_deser_16;

  logic       Clk = 1'b0;
  logic       Reset_n = 1'b0;
  logic       Start = 1'b0;
  logic       Shift_En = 1'b0;
  logic       Shift_In = 1'b0;
  logic       Ack = 1'b0;
  logic       Busy;
  logic       Valid;
  logic       Overrun;
  logic [7:0] Aout;
  logic [7:0] Bout;

  int passed = 0;
  int total  = 0;
  int cyc    = 0;
  int t0     = 0;
  logic [15:0] exp_q[$];
  logic [15:0] held;

  shift_deser_16 #(.HALF_W(8)) dut (
    .Clk      (Clk),
    .Reset_n  (Reset_n),
    .Start    (Start),
    .Shift_En (Shift_En),
    .Shift_In (Shift_In),
    .Ack      (Ack),
    .Busy     (Busy),
    .Valid    (Valid),
    .Overrun  (Overrun),
    .Aout     (Aout),
    .Bout     (Bout)
  );

  always #5 Clk = ~Clk;
  always @(posedge Clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // One-cycle Start pulse; returns at the following negedge.
  task automatic pulse_start();
    Start = 1'b1;
    @(negedge Clk);
    Start = 1'b0;
    t0 = cyc;
  endtask

  task automatic pulse_ack();
    Ack = 1'b1;
    @(negedge Clk);
    Ack = 1'b0;
  endtask

  // Send n bits of w LSB-first; optional stall of gap_len cycles before bit gap_at.
  task automatic send(input logic [15:0] w, input int n, input int gap_at, input int gap_len);
    for (int i = 0; i < n; i++) begin
      if (i == gap_at) begin
        Shift_En = 1'b0;
        repeat (gap_len) @(negedge Clk);
      end
      Shift_En = 1'b1;
      Shift_In = w[i];
      @(negedge Clk);
    end
    Shift_En = 1'b0;
  endtask

  // Bounded wait for Valid, then compare against the scoreboard head.
  task automatic expect_word(input string tag, input int exp_lat);
    int k;
    k = 0;
    while (!Valid && k < 40) begin
      @(negedge Clk);
      k++;
    end
    chk({tag, "_valid"}, Valid, 1'b1);
    chk({tag, "_latency"}, cyc - t0 + 1, exp_lat);
    if (exp_q.size() == 0) begin
      chk({tag, "_sb_nonempty"}, 0, 1);
    end else begin
      held = exp_q.pop_front();
      chk({tag, "_aout"}, Aout, held[15:8]);
      chk({tag, "_bout"}, Bout, held[7:0]);
    end
    chk({tag, "_busy"}, Busy, 1'b0);
  endtask

  initial begin
    // Reset state
    #2;
    chk("rst_busy", Busy, 0);
    chk("rst_valid", Valid, 0);
    chk("rst_ovr", Overrun, 0);
    chk("rst_ab", {Aout, Bout}, 16'h0000);
    @(negedge Clk);
    Reset_n = 1'b1;
    @(negedge Clk);

    // Basic frame, back-to-back bits: Valid at edge 17 counting Start as 1
    pulse_start();
    chk("f1_busy", Busy, 1);
    exp_q.push_back(16'hA53C);
    send(16'hA53C, 15, -1, 0);
    chk("f1_not_early", Valid, 0);
    send(16'hA53C >> 15, 1, -1, 0);
    expect_word("f1", 17);
    chk("f1_ovr", Overrun, 0);
    pulse_ack();
    chk("f1_ack_valid", Valid, 0);
    chk("f1_ack_busy", Busy, 0);

    // Same frame with a 3-cycle stall after bit 7: Valid at edge 20
    pulse_start();
    exp_q.push_back(16'hA53C);
    send(16'hA53C, 16, 8, 3);
    expect_word("f2", 20);

    // Overrun in HOLD, Start without Ack ignored
    Shift_En = 1'b1;
    Shift_In = 1'b1;
    Start    = 1'b1;
    @(negedge Clk);
    Shift_En = 1'b0;
    Start    = 1'b0;
    chk("ovr_set", Overrun, 1);
    chk("ovr_valid_kept", Valid, 1);
    chk("ovr_busy", Busy, 0);
    chk("ovr_ab_frozen", {Aout, Bout}, 16'hA53C);
    pulse_ack();
    chk("ovr_sticky", Overrun, 1);
    chk("ovr_idle_valid", Valid, 0);
    pulse_start();
    chk("ovr_cleared", Overrun, 0);
    chk("ovr_start_busy", Busy, 1);

    // Restart after 9 bits of FFFF; the Start-cycle bit must be discarded
    send(16'hFFFF, 9, -1, 0);
    Start    = 1'b1;
    Shift_En = 1'b1;
    Shift_In = 1'b1;
    @(negedge Clk);
    Start    = 1'b0;
    Shift_En = 1'b0;
    t0 = cyc;
    chk("rs_busy", Busy, 1);
    exp_q.push_back(16'h0001);
    send(16'h0001, 16, -1, 0);
    expect_word("rs", 17);

    // Ack and Start together in HOLD
    Ack   = 1'b1;
    Start = 1'b1;
    @(negedge Clk);
    Ack   = 1'b0;
    Start = 1'b0;
    t0 = cyc;
    chk("as_busy", Busy, 1);
    chk("as_valid", Valid, 0);
    exp_q.push_back(16'h8000);
    send(16'h8000, 16, -1, 0);
    expect_word("as", 17);
    pulse_ack();

    // Asynchronous reset mid-frame
    pulse_start();
    send(16'hA53C, 10, -1, 0);
    chk("ar_pre_busy", Busy, 1);
    #2;
    Reset_n = 1'b0;
    #1;
    chk("ar_busy", Busy, 0);
    chk("ar_valid", Valid, 0);
    chk("ar_ovr", Overrun, 0);
    chk("ar_ab", {Aout, Bout}, 16'h0000);
    @(negedge Clk);
    Reset_n = 1'b1;

    // Shift_En in IDLE has no effect
    Shift_En = 1'b1;
    Shift_In = 1'b1;
    repeat (20) @(negedge Clk);
    Shift_En = 1'b0;
    chk("idle_ab", {Aout, Bout}, 16'h0000);
    chk("idle_ovr", Overrun, 0);
    chk("idle_valid", Valid, 0);
    chk("idle_busy", Busy, 0);
    chk("sb_empty", exp_q.size(), 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule : tb_shift_deser_16
`default_nettype wire

// File: doc/shift_deser_16.md
# shift_deser_16

Serial-to-parallel receiver for the 16-bit A:B shift-register chain used by the multiplier datapath. It collects the chain's LSB-first serial stream (B[0] first, A[7] last) and rebuilds the original 16-bit word as two 8-bit halves, Aout and Bout. It sits at the far end of the serial link and presents each completed word to its consumer with a valid/ack handshake. It also flags bits that arrive while an unacknowledged word is still held.

## Interface
- HALF_W, 8, width of each half; the frame length is 2*HALF_W bits.
- Clk  input  1  rising-edge clock.
- Reset_n  input  1  asynchronous, active-low reset.
- Start  input  1  begins a new frame; clears the bit count.
- Shift_En  input  1  qualifies Shift_In; one bit is consumed per cycle while high.
- Shift_In  input  1  serial data bit.
- Ack  input  1  consumer has taken the held word.
- Busy  output  1  high while a frame is being received.
- Valid  output  1  high while a complete word is held.
- Overrun  output  1  sticky flag: a bit was dropped while in HOLD.
- Aout  output  HALF_W  upper half of the word (bits 2*HALF_W-1 : HALF_W).
- Bout  output  HALF_W  lower half of the word (bits HALF_W-1 : 0).

## Operation
- Internal shift register SR is 2*HALF_W bits. The counter CNT is $clog2(2*HALF_W) bits wide.
- Each accepted shift performs SR <= {Shift_In, SR[2*HALF_W-1:1]}, a right shift with the new bit entering the MSB. After 16 shifts, SR equals the transmitted word.
- Aout = SR[15:8] and Bout = SR[7:0], driven combinationally from SR. The contents are meaningful only while Valid=1.
- States:
  - IDLE: Shift_En is ignored (no shift, no overrun). Start -> RECV with CNT=0.
  - RECV: Start -> restart; CNT=0 and SR is retained. The Start-cycle bit is discarded even if Shift_En=1. Otherwise Shift_En -> shift and CNT++. When CNT==2*HALF_W-1 and Shift_En=1, shift and go to HOLD.
  - HOLD: SR is frozen.
    - Ack alone -> IDLE.
    - Ack with Start in the same cycle -> RECV with CNT=0.
    - Start without Ack is ignored.
    - Shift_En=1 without Ack sets Overrun; the bit is dropped.
    - Shift_En=1 with Ack -> bit dropped, no Overrun.
- Overrun clears only on reset, or on Start in IDLE or RECV.
- Busy = (state==RECV). Valid = (state==HOLD). Both are registered state decodes.
- Ack outside HOLD is ignored.

## Timing
- Reset (Reset_n low) immediately forces: state=IDLE, SR=0, CNT=0, Busy=0, Valid=0, Overrun=0, Aout=0, Bout=0.
- Reset asserted mid-frame or in HOLD discards the partial or held word; no Valid pulse follows.
- Start at edge k gives Busy=1 after edge k. The first bit can be accepted at edge k+1.
- With back-to-back Shift_En, the 16th bit accepted at edge n gives Valid=1 after edge n. Minimum frame time from Start is 17 cycles.
- Gaps in Shift_En stall reception indefinitely; there is no timeout.
- Ack at edge m gives Valid=0 after edge m. Valid holds for at least one cycle.

## Structure
- Shared package shift_pkg holds:
  - the state enum deser_state_t {IDLE, RECV, HOLD};
  - localparam FRAME_BITS = 2*HALF_W;
  - the bit-order constant LSB_FIRST = 1, shared with the transmit side.
- One sub-module: deser_shift_reg (parameter W; ports Clk, Reset_n, Shift_En, Shift_In, Q). It holds SR; the FSM and counter stay in the top level.

## Test plan
- Reset, then Start. Send 16'hA53C LSB-first on consecutive cycles: bits 0,0,1,1,1,1,0,0,1,0,1,0,0,1,0,1 → Valid=1 at edge 17, Aout=8'hA5, Bout=8'h3C, Overrun=0. Ack → Valid=0 and IDLE.
- Same frame with Shift_En deasserted for 3 cycles after bit 7 → same result, with Valid at edge 20.
- In HOLD, pulse Shift_En=1 without Ack → Overrun=1 and Aout/Bout unchanged. Then Start in IDLE after Ack → Overrun=0.
- Start after 9 bits of 16'hFFFF, then send 16'h0001 → Aout=8'h00, Bout=8'h01.
- Ack and Start in the same cycle in HOLD → Busy=1 next cycle. Then send 16'h8000 → Aout=8'h80, Bout=8'h00.
- Assert Reset_n low asynchronously after bit 10 → all outputs 0 immediately. Shift_En while in IDLE afterwards → no shift and Overrun stays 0.
